// File: rtl/distortion_core.sv
// distortion_core: gain -> symmetric clip stage for 16-bit signed PCM.
// Pipeline: S0 capture, S1 multiply, S2 clip folded into the output register,
// so out_valid follows in_valid by exactly 3 cycles with no stalls.
// Optional build macro DIST_SOFT_KNEE_EN replaces the hard clip with a 1/4-slope
// knee followed by saturation to +/-32767.
module distortion_core #(
    parameter int HOLD_CYCLES = 5000000,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic [15:0]      in_sample,
    input  logic             in_valid,
    input  logic             in_chan,
    input  logic [15:0]      gain,
    input  logic [31:0]      threshold,
    input  logic             disabled,
    input  logic             clr_count,
    output logic [15:0]      out_sample,
    output logic             out_valid,
    output logic             out_chan,
    output logic             clip_led,
    output logic [CNT_W-1:0] clip_count
);

    localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    // Gain below 1 (zero or negative) becomes 1; the signed 16-bit range caps it at 32767.
    function automatic logic [15:0] clamp_gain(input logic [15:0] g);
        if (g[15] || (g == 16'd0)) begin
            return 16'd1;
        end else begin
            return g;
        end
    endfunction

    // Threshold is forced into [1, 32767] so the clip window is never empty or wider than the PCM range.
    function automatic logic [15:0] clamp_thr(input logic [31:0] t);
        if (t[31] || (t == 32'd0)) begin
            return 16'd1;
        end else if (t > 32'd32767) begin
            return 16'd32767;
        end else begin
            return t[15:0];
        end
    endfunction

    logic               s0_valid_q;
    logic signed [15:0] s0_sample_q;
    logic               s0_chan_q;
    logic               s0_byp_q;
    logic signed [15:0] s0_gain_q;
    logic        [15:0] s0_thr_q;

    logic               s1_valid_q;
    logic signed [31:0] s1_prod_q;
    logic        [15:0] s1_sample_q;
    logic               s1_chan_q;
    logic               s1_byp_q;
    logic        [15:0] s1_thr_q;

    logic        [15:0] res_d;
    logic               clip_d;
    logic signed [31:0] thr_ext_s;
    logic signed [31:0] mag_s;
    logic signed [31:0] knee_s;
    logic [HW-1:0]      hold_q;
    logic [HW-1:0]      hold_d;
    logic [CNT_W-1:0]   count_d;

    // S0: capture sample and per-sample parameters so later control changes do not affect it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q  <= 1'b0;
            s0_sample_q <= 16'sd0;
            s0_chan_q   <= 1'b0;
            s0_byp_q    <= 1'b0;
            s0_gain_q   <= 16'sd1;
            s0_thr_q    <= 16'd1;
        end else begin
            s0_valid_q <= in_valid;
            if (in_valid) begin
                s0_sample_q <= in_sample;
                s0_chan_q   <= in_chan;
                s0_byp_q    <= disabled;
                s0_gain_q   <= clamp_gain(gain);
                s0_thr_q    <= clamp_thr(threshold);
            end else begin
                s0_sample_q <= s0_sample_q;
            end
        end
    end

    // S1: full-precision signed product; |sample * gain| < 2^31 so 32 bits never overflow.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= 32'sd0;
            s1_sample_q <= 16'd0;
            s1_chan_q   <= 1'b0;
            s1_byp_q    <= 1'b0;
            s1_thr_q    <= 16'd1;
        end else begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_prod_q   <= s0_sample_q * s0_gain_q;
                s1_sample_q <= s0_sample_q;
                s1_chan_q   <= s0_chan_q;
                s1_byp_q    <= s0_byp_q;
                s1_thr_q    <= s0_thr_q;
            end else begin
                s1_prod_q <= s1_prod_q;
            end
        end
    end

    // S2: clip (or knee) decision plus next values for the clip counter and LED hold counter.
    always_comb begin
        thr_ext_s = $signed({16'd0, s1_thr_q});
        mag_s     = 32'sd0;
        knee_s    = 32'sd0;
        res_d     = s1_prod_q[15:0];
        clip_d    = 1'b0;
        if (s1_byp_q) begin
            res_d  = s1_sample_q;
            clip_d = 1'b0;
        end else if ((s1_prod_q > thr_ext_s) || (s1_prod_q < -thr_ext_s)) begin
            clip_d = 1'b1;
            mag_s  = s1_prod_q[31] ? -s1_prod_q : s1_prod_q;
`ifdef DIST_SOFT_KNEE_EN
            knee_s = thr_ext_s + ((mag_s - thr_ext_s) >>> 2);
            if (knee_s > 32'sd32767) begin
                knee_s = 32'sd32767;
            end else begin
                knee_s = knee_s;
            end
`else
            knee_s = thr_ext_s;
`endif
            if (s1_prod_q[31]) begin
                res_d = 16'd0 - knee_s[15:0];
            end else begin
                res_d = knee_s[15:0];
            end
        end else begin
            res_d = s1_prod_q[15:0];
        end

        if (clr_count) begin
            count_d = {CNT_W{1'b0}};
        end else if (s1_valid_q && clip_d && (clip_count != {CNT_W{1'b1}})) begin
            count_d = clip_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = clip_count;
        end

        if (s1_valid_q && clip_d) begin
            hold_d = HW'(HOLD_CYCLES);
        end else if (hold_q != {HW{1'b0}}) begin
            hold_d = hold_q - {{(HW-1){1'b0}}, 1'b1};
        end else begin
            hold_d = hold_q;
        end
    end

    // Output register: sample, channel and strobe move together; counters and LED share the edge.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sample <= 16'd0;
            out_chan   <= 1'b0;
            clip_count <= {CNT_W{1'b0}};
            hold_q     <= {HW{1'b0}};
            clip_led   <= 1'b0;
        end else begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_sample <= res_d;
                out_chan   <= s1_chan_q;
            end else begin
                out_sample <= out_sample;
            end
            clip_count <= count_d;
            hold_q     <= hold_d;
            clip_led   <= (hold_d != {HW{1'b0}});
        end
    end

endmodule

// File: tb/tb_distortion_core.sv
// Directed bench for distortion_core (HOLD_CYCLES=8, CNT_W=4 for short runs).
module tb_distortion_core;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [15:0] in_sample;
    logic        in_valid;
    logic        in_chan;
    logic [15:0] gain;
    logic [31:0] threshold;
    logic        disabled;
    logic        clr_count;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_chan;
    logic        clip_led;
    logic [3:0]  clip_count;

    int vectors = 0;
    int miscompares = 0;

    distortion_core #(.HOLD_CYCLES(8), .CNT_W(4)) dut (
        .CLK(CLK), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
        .in_chan(in_chan), .gain(gain), .threshold(threshold), .disabled(disabled),
        .clr_count(clr_count), .out_sample(out_sample), .out_valid(out_valid),
        .out_chan(out_chan), .clip_led(clip_led), .clip_count(clip_count)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [15:0] s, input logic [15:0] g, input logic [31:0] t,
                         input logic d, input logic ch);
        in_valid  = 1'b1;
        in_sample = s;
        gain      = g;
        threshold = t;
        disabled  = d;
        in_chan   = ch;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step;
        vectors++;
        if ({out_sample, out_valid, out_chan, clip_led, clip_count} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got s=%h v=%b c=%b led=%b cnt=%0d required all 0",
                     out_sample, out_valid, out_chan, clip_led, clip_count);
        end
        rst_n = 1'b1;
        repeat (4) step;
        vectors++;
        if ({out_sample, out_valid, out_chan, clip_led, clip_count} !== 23'd0) begin
            miscompares++;
            $display("FAIL idle_outputs: got s=%h v=%b c=%b led=%b cnt=%0d required all 0",
                     out_sample, out_valid, out_chan, clip_led, clip_count);
        end
    endtask

    task automatic test_linear;
        drive(16'd1000, 16'd2, 32'd32000, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        step;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL linear_early_valid: got %b required 0", out_valid);
        end
        step;
        vectors++;
        if ({out_valid, out_sample} !== {1'b1, 16'd2000}) begin
            miscompares++;
            $display("FAIL linear_out: got v=%b s=%0d required v=1 s=2000", out_valid, $signed(out_sample));
        end
        vectors++;
        if (clip_count !== 4'd0) begin
            miscompares++;
            $display("FAIL linear_count: got %0d required 0", clip_count);
        end
        step;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL linear_late_valid: got %b required 0", out_valid);
        end
    endtask

    task automatic test_hard_clip;
        drive(16'd100, 16'd10, 32'd500, 1'b0, 1'b1);
        step;
        drive(16'hFF9C, 16'd10, 32'd500, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        step;
        vectors++;
        if ({out_valid, out_chan, out_sample} !== {1'b1, 1'b1, 16'd500}) begin
            miscompares++;
            $display("FAIL clip_pos: got v=%b c=%b s=%0d required v=1 c=1 s=500",
                     out_valid, out_chan, $signed(out_sample));
        end
        step;
        vectors++;
        if ({out_valid, out_chan, out_sample} !== {1'b1, 1'b0, 16'hFE0C}) begin
            miscompares++;
            $display("FAIL clip_neg: got v=%b c=%b s=%0d required v=1 c=0 s=-500",
                     out_valid, out_chan, $signed(out_sample));
        end
        vectors++;
        if ({clip_count, clip_led} !== {4'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL clip_count_led: got cnt=%0d led=%b required cnt=2 led=1", clip_count, clip_led);
        end
        repeat (7) step;
        vectors++;
        if (clip_led !== 1'b1) begin
            miscompares++;
            $display("FAIL led_hold_last: got %b required 1", clip_led);
        end
        step;
        vectors++;
        if (clip_led !== 1'b0) begin
            miscompares++;
            $display("FAIL led_expire: got %b required 0", clip_led);
        end
        vectors++;
        if ({out_valid, out_sample} !== {1'b0, 16'hFE0C}) begin
            miscompares++;
            $display("FAIL idle_hold: got v=%b s=%0d required v=0 s=-500", out_valid, $signed(out_sample));
        end
    endtask

    task automatic test_clamps;
        drive(16'd7, 16'd0, 32'hFFFF_FFFB, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        step;
        step;
        vectors++;
        if ({out_valid, out_sample, clip_count} !== {1'b1, 16'd1, 4'd3}) begin
            miscompares++;
            $display("FAIL clamp: got v=%b s=%0d cnt=%0d required v=1 s=1 cnt=3",
                     out_valid, $signed(out_sample), clip_count);
        end
        drive(16'h8000, 16'd50, 32'd32000, 1'b1, 1'b1);
        step;
        in_valid = 1'b0;
        step;
        step;
        vectors++;
        if ({out_valid, out_sample, clip_count} !== {1'b1, 16'h8000, 4'd3}) begin
            miscompares++;
            $display("FAIL bypass: got v=%b s=%0d cnt=%0d required v=1 s=-32768 cnt=3",
                     out_valid, $signed(out_sample), clip_count);
        end
        disabled = 1'b0;
    endtask

    task automatic test_capture_reset;
        drive(16'd300, 16'd1, 32'd32000, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        gain     = 16'd50;
        step;
        step;
        vectors++;
        if ({out_valid, out_sample} !== {1'b1, 16'd300}) begin
            miscompares++;
            $display("FAIL capture: got v=%b s=%0d required v=1 s=300", out_valid, $signed(out_sample));
        end
        drive(16'd300, 16'd50, 32'd500, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        step;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, clip_count} !== {1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: got v=%b cnt=%0d required v=0 cnt=0", out_valid, clip_count);
        end
        step;
        step;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            vectors++;
            if ({out_valid, clip_count} !== {1'b0, 4'd0}) begin
                miscompares++;
                $display("FAIL reset_flush_%0d: got v=%b cnt=%0d required v=0 cnt=0", i, out_valid, clip_count);
            end
        end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 17; i++) begin
            drive(16'd100, 16'd10, 32'd500, 1'b0, 1'b0);
            step;
        end
        in_valid = 1'b0;
        step;
        step;
        vectors++;
        if (clip_count !== 4'd15) begin
            miscompares++;
            $display("FAIL count_saturate: got %0d required 15", clip_count);
        end
        drive(16'd100, 16'd10, 32'd500, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        step;
        clr_count = 1'b1;
        step;
        clr_count = 1'b0;
        vectors++;
        if ({out_valid, clip_count} !== {1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL clear_priority: got v=%b cnt=%0d required v=1 cnt=0", out_valid, clip_count);
        end
    endtask

    task automatic test_knee;
        logic [15:0] exp_pos;
        logic [15:0] exp_neg;
        logic [15:0] exp_sat;
`ifdef DIST_SOFT_KNEE_EN
        exp_pos = 16'd1250;
        exp_neg = 16'hFB1E;
        exp_sat = 16'd32767;
`else
        exp_pos = 16'd1000;
        exp_neg = 16'hFC18;
        exp_sat = 16'd30000;
`endif
        drive(16'd2000, 16'd1, 32'd1000, 1'b0, 1'b0);
        step;
        drive(16'hF830, 16'd1, 32'd1000, 1'b0, 1'b1);
        step;
        drive(16'd1000, 16'd100, 32'd30000, 1'b0, 1'b0);
        step;
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_sample} !== {1'b1, exp_pos}) begin
            miscompares++;
            $display("FAIL knee_pos: got v=%b s=%0d required v=1 s=%0d", out_valid, $signed(out_sample), $signed(exp_pos));
        end
        step;
        vectors++;
        if ({out_valid, out_sample} !== {1'b1, exp_neg}) begin
            miscompares++;
            $display("FAIL knee_neg: got v=%b s=%0d required v=1 s=%0d", out_valid, $signed(out_sample), $signed(exp_neg));
        end
        step;
        vectors++;
        if ({out_valid, out_sample} !== {1'b1, exp_sat}) begin
            miscompares++;
            $display("FAIL knee_sat: got v=%b s=%0d required v=1 s=%0d", out_valid, $signed(out_sample), $signed(exp_sat));
        end
        vectors++;
        if (clip_count !== 4'd3) begin
            miscompares++;
            $display("FAIL knee_count: got %0d required 3", clip_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_sample = 16'd0;
        in_valid  = 1'b0;
        in_chan   = 1'b0;
        gain      = 16'd1;
        threshold = 32'd32000;
        disabled  = 1'b0;
        clr_count = 1'b0;
        test_reset;
        test_linear;
        test_hard_clip;
        test_clamps;
        test_capture_reset;
        test_saturate;
        test_knee;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
